button_pulse_bank: RTL

- Parametrised, multi-channel successor to the single-button one-shot conditioner.
- Per channel: synchronises a raw button input, debounces it, emits a one-cycle press pulse on each debounced rising edge and a one-cycle release pulse on each debounced falling edge.
- Optional per-channel auto-repeat: a held button emits repeat pulses after a delay.
- Sits between board push-buttons and game-control logic, e.g. flap and start inputs.

---
 rtl/button_pulse_bank.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/button_pulse_bank.sv
// button_pulse_bank: multi-channel push-button conditioner.
// Each channel has its own synchroniser, debouncer, edge pulses and auto-repeat scheduler.
// Channels do not interact.
//
// Ports:
//   clk       system clock; all state updates on the rising edge
//   reset     asynchronous, active-high; clears all state
//   in        raw asynchronous button levels, bit i = channel i
//   repeat_en per-channel auto-repeat enable (synchronous level)
//   held      debounced button level
//   press     one-cycle pulse on each debounced rising edge
//   pulse     press OR auto-repeat pulse; main consumer output
//   released  one-cycle pulse on each debounced falling edge
//             (named this way because `release` is a reserved word)
module button_pulse_bank #(
  parameter int unsigned N               = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] held,
  output logic [N-1:0] press,
  output logic [N-1:0] pulse,
  output logic [N-1:0] released
);

  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMax + 1);

  localparam logic [DW-1:0] DebLast    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DelayLast  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PeriodLast = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_st_e;

  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  sq;
  logic [DW-1:0] cnt_q  [N];
  logic [DW-1:0] cnt_d  [N];
  logic [N-1:0]  held_q, held_d;
  logic [N-1:0]  rise, fall, rep;
  logic [N-1:0]  press_q, pulse_q, release_q;
  rep_st_e       st_q   [N];
  rep_st_e       st_d   [N];
  logic [RW-1:0] rcnt_q [N];
  logic [RW-1:0] rcnt_d [N];

  assign sq = sync_q[SYNC_STAGES-1];

  // Debounce: the synchronised level must disagree with held for DEBOUNCE_CYCLES
  // consecutive edges; one cycle of agreement restarts the count.
  always_comb begin
    cnt_d  = cnt_q;
    held_d = held_q;
    rise   = '0;
    fall   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (sq[i] == held_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DebLast) begin
        cnt_d[i]  = '0;
        held_d[i] = sq[i];
        rise[i]   = sq[i];
        fall[i]   = ~sq[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  // Auto-repeat scheduler. Only a fresh press can start it; leaving on a held fall
  // or a low repeat_en takes priority over a repeat due on the same edge.
  always_comb begin
    st_d   = st_q;
    rcnt_d = rcnt_q;
    rep    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      unique case (st_q[i])
        StIdle: begin
          if (rise[i] && repeat_en[i]) begin
            st_d[i]   = StDelay;
            rcnt_d[i] = '0;
          end
        end
        StDelay: begin
          if (fall[i] || !repeat_en[i]) begin
            st_d[i]   = StIdle;
            rcnt_d[i] = '0;
          end else if (rcnt_q[i] == DelayLast) begin
            st_d[i]   = StRepeat;
            rcnt_d[i] = '0;
            rep[i]    = 1'b1;
          end else begin
            rcnt_d[i] = rcnt_q[i] + RW'(1);
          end
        end
        StRepeat: begin
          if (fall[i] || !repeat_en[i]) begin
            st_d[i]   = StIdle;
            rcnt_d[i] = '0;
          end else if (rcnt_q[i] == PeriodLast) begin
            rcnt_d[i] = '0;
            rep[i]    = 1'b1;
          end else begin
            rcnt_d[i] = rcnt_q[i] + RW'(1);
          end
        end
        default: begin
          st_d[i]   = StIdle;
          rcnt_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '{default: '0};
      cnt_q     <= '{default: '0};
      held_q    <= '0;
      press_q   <= '0;
      pulse_q   <= '0;
      release_q <= '0;
      st_q      <= '{default: StIdle};
      rcnt_q    <= '{default: '0};
    end else begin
      sync_q[0] <= in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      press_q   <= rise;
      release_q <= fall;
      pulse_q   <= rise | rep;
      st_q      <= st_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign held     = held_q;
  assign press    = press_q;
  assign pulse    = pulse_q;
  assign released = release_q;

endmodule
